// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default widths for the CPU run/halt/step controller.
package cpu_ctrl_pkg;

    localparam int PC_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        HALT = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } run_state_t;

    // The core clock is enabled only while free running or single stepping.
    function automatic logic enables_core(input run_state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clear has priority, increment stops at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer: owns the core reset and clock enable,
// handles host commands and a PC breakpoint, and counts executed cycles.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int HOLD_CYCLES = 2,
    parameter int AUTO_RUN    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_cmd,
    input  logic             halt_cmd,
    input  logic             step_cmd,
    input  logic             soft_reset_cmd,
    input  logic             clr_count,
    input  logic             bp_enable,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_reset,
    output logic             cpu_run_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic             break_hit,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    run_state_t        state_r;
    run_state_t        state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_nxt_s;
    logic              break_hit_r;
    logic              break_hit_nxt_s;
    logic              first_run_r;
    logic              first_run_nxt_s;
    logic              bp_match_s;
    logic              cpu_reset_s;
    logic              cpu_run_en_s;
    logic              halted_s;

    // State register and sequencing flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= HOLD;
            hold_cnt_r  <= HOLD_RELOAD;
            break_hit_r <= 1'b0;
            first_run_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            break_hit_r <= break_hit_nxt_s;
            first_run_r <= first_run_nxt_s;
        end
    end

    // Next-state decode; soft reset overrides every other command.
    always_comb begin
        state_nxt_s     = state_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        break_hit_nxt_s = break_hit_r;
        bp_match_s      = 1'b0;
        if (soft_reset_cmd) begin
            state_nxt_s     = HOLD;
            hold_cnt_nxt_s  = HOLD_RELOAD;
            break_hit_nxt_s = 1'b0;
        end else begin
            case (state_r)
                HOLD: begin
                    if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                        state_nxt_s     = (AUTO_RUN != 0) ? RUN : HALT;
                        break_hit_nxt_s = 1'b0;
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r - HOLD_W'(1);
                    end
                end
                HALT: begin
                    if (halt_cmd) begin
                        state_nxt_s = HALT;
                    end else if (step_cmd) begin
                        state_nxt_s     = STEP;
                        break_hit_nxt_s = 1'b0;
                    end else if (run_cmd) begin
                        state_nxt_s     = RUN;
                        break_hit_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = HALT;
                    end
                end
                STEP: begin
                    state_nxt_s = HALT;
                end
                RUN: begin
                    // Skipping the first RUN cycle lets the core resume from the breakpoint address.
                    bp_match_s = bp_enable && (pc == bp_addr) && !first_run_r;
                    if (bp_match_s) begin
                        state_nxt_s     = HALT;
                        break_hit_nxt_s = 1'b1;
                    end else if (halt_cmd) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s    = HOLD;
                    hold_cnt_nxt_s = HOLD_RELOAD;
                end
            endcase
        end
        first_run_nxt_s = (state_nxt_s == RUN) && (state_r != RUN);
    end

    // Output decode straight from the registered state.
    always_comb begin
        cpu_reset_s  = (state_r == HOLD);
        cpu_run_en_s = enables_core(state_r);
        halted_s     = (state_r == HALT);
    end

    assign cpu_reset  = cpu_reset_s;
    assign cpu_run_en = cpu_run_en_s;
    assign halted     = halted_s;
    assign state      = state_r;
    assign break_hit  = break_hit_r;

    sat_counter #(
        .W(CNT_W)
    ) u_cycle_counter (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_count),
        .inc  (cpu_run_en_s),
        .count(cycle_count)
    );

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed, table-driven bench for cpu_run_controller with default parameters.
module tb_cpu_run_controller;

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STEP = 2'd3;

    // Command bits: {run, halt, step, soft_reset, clr_count, bp_enable}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_RUN  = 6'b100000;
    localparam logic [5:0] C_HALT = 6'b010000;
    localparam logic [5:0] C_STEP = 6'b001000;
    localparam logic [5:0] C_SRST = 6'b000100;
    localparam logic [5:0] C_CLR  = 6'b000010;
    localparam logic [5:0] C_BP   = 6'b000001;

    typedef struct {
        logic [5:0]  cmd;
        logic [7:0]  pc;
        logic [1:0]  st;
        logic        brk;
        logic [15:0] cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_cmd, halt_cmd, step_cmd, soft_reset_cmd, clr_count, bp_enable;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic        cpu_reset, cpu_run_en, halted, break_hit;
    logic [1:0]  state;
    logic [15:0] cycle_count;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];

    cpu_run_controller dut (
        .clk           (clk),
        .reset         (reset),
        .run_cmd       (run_cmd),
        .halt_cmd      (halt_cmd),
        .step_cmd      (step_cmd),
        .soft_reset_cmd(soft_reset_cmd),
        .clr_count     (clr_count),
        .bp_enable     (bp_enable),
        .bp_addr       (bp_addr),
        .pc            (pc),
        .cpu_reset     (cpu_reset),
        .cpu_run_en    (cpu_run_en),
        .state         (state),
        .halted        (halted),
        .break_hit     (break_hit),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [5:0] c, input logic [7:0] p, input logic [1:0] s,
                       input logic b, input logic [15:0] n);
        vec_t v;
        v.cmd = c; v.pc = p; v.st = s; v.brk = b; v.cnt = n;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] c, input logic [7:0] p);
        {run_cmd, halt_cmd, step_cmd, soft_reset_cmd, clr_count, bp_enable} = c;
        pc = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Compares every output against an expected state; the control outputs follow the state encoding.
    task automatic check_all(input int idx, input logic [1:0] s, input logic b, input logic [15:0] n);
        check("state",       idx, {14'd0, state},      {14'd0, s});
        check("cpu_reset",   idx, {15'd0, cpu_reset},  {15'd0, (s == S_HOLD)});
        check("cpu_run_en",  idx, {15'd0, cpu_run_en}, {15'd0, (s == S_RUN) || (s == S_STEP)});
        check("halted",      idx, {15'd0, halted},     {15'd0, (s == S_HALT)});
        check("break_hit",   idx, {15'd0, break_hit},  {15'd0, b});
        check("cycle_count", idx, cycle_count,         n);
    endtask

    initial begin
        bp_addr = 8'h05;
        reset   = 1'b1;
        drive(C_NONE, 8'h00);

        // Reset release, then three steps four cycles apart.
        add(C_NONE, 8'h00, S_HOLD, 1'b0, 16'd0);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd0);
        add(C_STEP, 8'h00, S_STEP, 1'b0, 16'd0);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd1);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd1);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd1);
        add(C_STEP, 8'h00, S_STEP, 1'b0, 16'd1);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd2);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd2);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd2);
        add(C_STEP, 8'h00, S_STEP, 1'b0, 16'd2);
        add(C_RUN,  8'h00, S_HALT, 1'b0, 16'd3);
        // Command priority in HALT.
        add(C_HALT, 8'h00, S_HALT, 1'b0, 16'd3);
        add(C_HALT | C_STEP | C_RUN, 8'h00, S_HALT, 1'b0, 16'd3);
        add(C_STEP | C_RUN, 8'h00, S_STEP, 1'b0, 16'd3);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd4);
        add(C_CLR,  8'h00, S_HALT, 1'b0, 16'd0);
        // Free run for 10 cycles, with ignored step/run, then halt.
        add(C_RUN,  8'h00, S_RUN,  1'b0, 16'd0);
        for (int i = 1; i <= 10; i++)
            add((i == 2) ? C_STEP : ((i == 3) ? C_RUN : C_NONE), 8'h00, S_RUN, 1'b0, 16'(i));
        add(C_HALT, 8'h00, S_HALT, 1'b0, 16'd11);
        // Breakpoint at 0x05 with an incrementing pc.
        add(C_CLR | C_BP, 8'h00, S_HALT, 1'b0, 16'd0);
        add(C_RUN | C_BP, 8'h00, S_RUN,  1'b0, 16'd0);
        for (int p = 0; p <= 4; p++)
            add(C_BP, 8'(p), S_RUN, 1'b0, 16'(p + 1));
        add(C_BP, 8'h05, S_HALT, 1'b1, 16'd6);
        add(C_BP, 8'h05, S_HALT, 1'b1, 16'd6);
        add(C_RUN | C_BP, 8'h05, S_RUN, 1'b0, 16'd6);
        add(C_BP, 8'h05, S_RUN, 1'b0, 16'd7);
        add(C_BP, 8'h06, S_RUN, 1'b0, 16'd8);
        // All commands at once in RUN with a live breakpoint match: soft reset wins.
        add(C_RUN | C_HALT | C_STEP | C_SRST | C_BP, 8'h05, S_HOLD, 1'b0, 16'd9);
        add(C_BP, 8'h00, S_HOLD, 1'b0, 16'd9);
        add(C_BP, 8'h00, S_HALT, 1'b0, 16'd9);
        // Halt together with a breakpoint match still flags the breakpoint.
        add(C_RUN | C_BP, 8'h00, S_RUN, 1'b0, 16'd9);
        add(C_BP, 8'h00, S_RUN, 1'b0, 16'd10);
        add(C_HALT | C_BP, 8'h05, S_HALT, 1'b1, 16'd11);
        // Soft reset from HALT clears break_hit; step is ignored in HOLD.
        add(C_SRST, 8'h00, S_HOLD, 1'b0, 16'd11);
        add(C_NONE, 8'h00, S_HOLD, 1'b0, 16'd11);
        add(C_STEP, 8'h00, S_HALT, 1'b0, 16'd11);
        add(C_NONE, 8'h00, S_HALT, 1'b0, 16'd11);

        tick();
        check_all(-1, S_HOLD, 1'b0, 16'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].cmd, vecs[i].pc);
            tick();
            check_all(i, vecs[i].st, vecs[i].brk, vecs[i].cnt);
        end

        // Saturation: run up to 0xFFFE, then keep running past all-ones.
        drive(C_RUN | C_CLR, 8'h00);
        tick();
        check_all(1000, S_RUN, 1'b0, 16'd0);
        drive(C_NONE, 8'h00);
        repeat (32'hFFFD) tick();
        drive(C_HALT, 8'h00);
        tick();
        check_all(1001, S_HALT, 1'b0, 16'hFFFE);
        drive(C_RUN, 8'h00);
        tick();
        check_all(1002, S_RUN, 1'b0, 16'hFFFE);
        drive(C_NONE, 8'h00);
        tick();
        check_all(1003, S_RUN, 1'b0, 16'hFFFF);
        repeat (3) tick();
        check_all(1004, S_RUN, 1'b0, 16'hFFFF);
        // Clear wins over the increment of an enabled cycle.
        drive(C_CLR, 8'h00);
        tick();
        check_all(1005, S_RUN, 1'b0, 16'h0000);
        drive(C_NONE, 8'h00);
        tick();
        check_all(1006, S_RUN, 1'b0, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
